// File: rtl/branch_resolve_predict_pkg.sv
// ============================================================================
// Module  : branch_resolve_predict_pkg
// Purpose : Branch funct3 codes, BHT counter encodings and reset default.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_resolve_predict_pkg;

    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    localparam logic [1:0] c_CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] c_CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] c_CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] c_CTR_STRONG_T  = 2'b11;

    localparam logic [1:0] c_BHT_INIT_DEFAULT = c_CTR_WEAK_NT;

endpackage

`default_nettype wire

// File: rtl/branch_resolve_predict_bht_counter_array.sv
// ============================================================================
// Module  : bht_counter_array
// Purpose : ENTRIES x 2-bit saturating counters, async read, single write.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_counter_array
    import branch_resolve_predict_pkg::*;
#(
    parameter int         ENTRIES    = 64,
    parameter int         IDX_W      = 6,
    parameter logic [1:0] INIT_STATE = c_BHT_INIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    logic [1:0] r_ctr [ENTRIES];
    logic [1:0] w_wr_old;
    logic [1:0] w_wr_new;

    // Read returns stored state only: a same-cycle write is not forwarded.
    assign o_rd_ctr = r_ctr[i_rd_idx];
    assign w_wr_old = r_ctr[i_wr_idx];

    always_comb begin
        w_wr_new = w_wr_old;
        if (i_wr_taken) begin
            if (w_wr_old != c_CTR_STRONG_T)
                w_wr_new = w_wr_old + 2'd1;
        end else begin
            if (w_wr_old != c_CTR_STRONG_NT)
                w_wr_new = w_wr_old - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                r_ctr[i] <= INIT_STATE;
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= w_wr_new;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_predict.sv
// ============================================================================
// Module  : branch_resolve_predict
// Purpose : EX branch resolution with bimodal BHT training and statistics.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_predict
    import branch_resolve_predict_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] INIT_STATE  = c_BHT_INIT_DEFAULT,
    parameter int         CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            res_valid,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic [XLEN-1:0] res_redirect_pc,
    output logic            res_illegal,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int              IDX_W     = $clog2(BHT_ENTRIES);
    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    logic [IDX_W-1:0] w_f_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic [1:0]       w_rd_ctr;
    logic             w_accept;
    logic             w_illegal;
    logic             w_taken;
    logic             w_bht_we;
    logic             w_unused_pc_bits;

    logic            r_res_valid;
    logic            r_res_taken;
    logic            r_res_mispredict;
    logic [XLEN-1:0] r_res_redirect_pc;
    logic            r_res_illegal;
    logic [CNT_W-1:0] r_stat_branches;
    logic [CNT_W-1:0] r_stat_mispredicts;

    assign w_f_idx          = f_pc[IDX_W+1:2];
    assign w_ex_idx         = ex_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0]};
    assign w_accept         = ex_valid & ~ex_stall;
    assign w_illegal        = (ex_funct3 == 3'b010) || (ex_funct3 == 3'b011);
    assign w_bht_we         = w_accept & ~w_illegal;

    always_comb begin
        w_taken = 1'b0;
        case (ex_funct3)
            c_F3_BEQ:  w_taken = (ex_a == ex_b);
            c_F3_BNE:  w_taken = (ex_a != ex_b);
            c_F3_BLT:  w_taken = ($signed(ex_a) <  $signed(ex_b));
            c_F3_BGE:  w_taken = ($signed(ex_a) >= $signed(ex_b));
            c_F3_BLTU: w_taken = (ex_a <  ex_b);
            c_F3_BGEU: w_taken = (ex_a >= ex_b);
            default:   w_taken = 1'b0;
        endcase
    end

    bht_counter_array #(
        .ENTRIES    (BHT_ENTRIES),
        .IDX_W      (IDX_W),
        .INIT_STATE (INIT_STATE)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_f_idx),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (w_bht_we),
        .i_wr_idx   (w_ex_idx),
        .i_wr_taken (w_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid        <= 1'b0;
            r_res_taken        <= 1'b0;
            r_res_mispredict   <= 1'b0;
            r_res_redirect_pc  <= '0;
            r_res_illegal      <= 1'b0;
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            r_res_valid <= w_accept;
            if (w_accept) begin
                r_res_taken       <= w_taken;
                r_res_mispredict  <= w_taken ^ ex_pred_taken;
                r_res_redirect_pc <= w_taken ? ex_target : (ex_pc + c_PC_STEP);
                r_res_illegal     <= w_illegal;
            end
            // Illegal encodings never count; both stats stick at all-ones.
            if (w_bht_we) begin
                if (r_stat_branches != '1)
                    r_stat_branches <= r_stat_branches + CNT_W'(1);
                if ((w_taken != ex_pred_taken) && (r_stat_mispredicts != '1))
                    r_stat_mispredicts <= r_stat_mispredicts + CNT_W'(1);
            end
        end
    end

    assign f_pred_taken     = w_rd_ctr[1];
    assign res_valid        = r_res_valid;
    assign res_taken        = r_res_taken;
    assign res_mispredict   = r_res_mispredict;
    assign res_redirect_pc  = r_res_redirect_pc;
    assign res_illegal      = r_res_illegal;
    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_predict.sv
// ============================================================================
// Module  : tb_branch_resolve_predict
// Purpose : Scoreboard bench for branch_resolve_predict (CNT_W=4).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_predict;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [XLEN-1:0]  f_pc;
    logic             f_pred_taken;
    logic             ex_valid, ex_stall, ex_pred_taken;
    logic [2:0]       ex_funct3;
    logic [XLEN-1:0]  ex_a, ex_b, ex_pc, ex_target;
    logic             res_valid, res_taken, res_mispredict, res_illegal;
    logic [XLEN-1:0]  res_redirect_pc;
    logic [CNT_W-1:0] stat_branches, stat_mispredicts;

    always #5 clk = ~clk;

    branch_resolve_predict #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (ENTRIES),
        .INIT_STATE  (2'b01),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .f_pc             (f_pc),
        .f_pred_taken     (f_pred_taken),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_funct3        (ex_funct3),
        .ex_a             (ex_a),
        .ex_b             (ex_b),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_mispredict   (res_mispredict),
        .res_redirect_pc  (res_redirect_pc),
        .res_illegal      (res_illegal),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct packed {
        logic            taken;
        logic            mis;
        logic            illegal;
        logic [XLEN-1:0] rpc;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   m_br, m_mis;
    logic [1:0] m_bht [ENTRIES];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [XLEN-1:0] a, b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_bht[i] = 2'b01;
        m_br  = 0;
        m_mis = 0;
        q_exp.delete();
    endtask

    task automatic check_pred(input string tag, input logic [XLEN-1:0] pc);
        f_pc = pc;
        #1;
        chk(tag, f_pred_taken, m_bht[idx_of(pc)][1]);
    endtask

    task automatic check_stats();
        chk("stat_branches", stat_branches, m_br);
        chk("stat_mispredicts", stat_mispredicts, m_mis);
    endtask

    // Called at a negedge; returns at the following negedge with EX idle.
    task automatic do_branch(input logic [2:0] f3, input logic [XLEN-1:0] a, b, pc, tgt,
                             input logic pred);
        exp_t e;
        logic t;
        logic ill;
        int   ix;
        ex_funct3 = f3; ex_a = a; ex_b = b; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pred; ex_valid = 1'b1; ex_stall = 1'b0;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
        t   = ref_taken(f3, a, b);
        e.taken   = t;
        e.mis     = t ^ pred;
        e.illegal = ill;
        e.rpc     = t ? tgt : pc + 32'd4;
        q_exp.push_back(e);
        if (!ill) begin
            ix = idx_of(pc);
            if (t && m_bht[ix] != 2'b11) m_bht[ix] = m_bht[ix] + 2'd1;
            if (!t && m_bht[ix] != 2'b00) m_bht[ix] = m_bht[ix] - 2'd1;
            if (m_br < CNT_MAX) m_br++;
            if (e.mis && m_mis < CNT_MAX) m_mis++;
        end
        @(posedge clk); #1;
        pop_check();
        check_stats();
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic pop_check();
        exp_t e;
        chk("res_valid", res_valid, 1'b1);
        if (res_valid && q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk("res_taken", res_taken, e.taken);
            chk("res_mispredict", res_mispredict, e.mis);
            chk("res_illegal", res_illegal, e.illegal);
            chk("res_redirect_pc", res_redirect_pc, e.rpc);
        end
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        chk("res_valid_idle", res_valid, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; f_pc = '0; ex_valid = 1'b0; ex_stall = 1'b0; ex_funct3 = '0;
        ex_a = '0; ex_b = '0; ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_taken", res_taken, 1'b0);
        chk("rst_res_mis", res_mispredict, 1'b0);
        chk("rst_res_illegal", res_illegal, 1'b0);
        chk("rst_redirect", res_redirect_pc, 32'h0);
        check_stats();
        check_pred("pred_rst_100", 32'h100);

        // Mispredicted beq trains weak-NT to weak-T.
        do_branch(3'b000, 32'd5, 32'd5, 32'h100, 32'h200, 1'b0);
        check_pred("pred_after_beq", 32'h100);
        chk("pred_100_taken", f_pred_taken, 1'b1);
        idle_check();

        do_branch(3'b100, 32'hFFFFFFFF, 32'd1, 32'h104, 32'h40, 1'b0);
        do_branch(3'b110, 32'hFFFFFFFF, 32'd1, 32'h104, 32'h40, 1'b1);
        do_branch(3'b110, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFC, 32'h80, 1'b0);
        do_branch(3'b101, 32'h80000000, 32'd0, 32'h108, 32'h90, 1'b1);
        do_branch(3'b111, 32'h80000000, 32'd0, 32'h10C, 32'h94, 1'b1);
        do_branch(3'b001, 32'd3, 32'd4, 32'h110, 32'h98, 1'b0);

        // Saturate at strong-T, then one not-taken leaves weak-T.
        for (int i = 0; i < 4; i++) begin
            check_pred("pred_sat_pre", 32'h308);
            do_branch(3'b000, 32'd7, 32'd7, 32'h308, 32'h400, f_pred_taken);
        end
        do_branch(3'b001, 32'd7, 32'd7, 32'h308, 32'h400, 1'b1);
        check_pred("pred_after_sat_nt", 32'h308);
        chk("pred_308_still_taken", f_pred_taken, 1'b1);

        // Stalled branch must not be accepted.
        ex_funct3 = 3'b000; ex_a = 32'd1; ex_b = 32'd1; ex_pc = 32'h40;
        ex_target = 32'h500; ex_pred_taken = 1'b0; ex_valid = 1'b1; ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_res_valid", res_valid, 1'b0);
            check_stats();
            check_pred("stall_pred", 32'h40);
            @(negedge clk);
        end
        ex_valid = 1'b0; ex_stall = 1'b0;
        do_branch(3'b000, 32'd1, 32'd1, 32'h40, 32'h500, 1'b0);
        idle_check();

        // Illegal funct3: no training, no counting.
        do_branch(3'b010, 32'd9, 32'd9, 32'h308, 32'h600, 1'b1);
        check_pred("pred_after_illegal", 32'h308);
        do_branch(3'b011, 32'd9, 32'd9, 32'h308, 32'h600, 1'b0);

        // Same-cycle read and write at index 5: read sees the old value.
        f_pc = 32'h14;
        ex_funct3 = 3'b000; ex_a = 32'd2; ex_b = 32'd2; ex_pc = 32'h14;
        ex_target = 32'h700; ex_pred_taken = 1'b0; ex_valid = 1'b1; ex_stall = 1'b0;
        #1;
        chk("same_cycle_old_pred", f_pred_taken, 1'b0);
        m_bht[5] = 2'b10;
        if (m_br < CNT_MAX) m_br++;
        if (m_mis < CNT_MAX) m_mis++;
        q_exp.push_back('{taken: 1'b1, mis: 1'b1, illegal: 1'b0, rpc: 32'h700});
        @(posedge clk); #1;
        pop_check();
        chk("next_cycle_new_pred", f_pred_taken, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;

        // Asynchronous reset between edges discards the in-flight result.
        ex_funct3 = 3'b000; ex_a = 32'd1; ex_b = 32'd1; ex_pc = 32'h100;
        ex_target = 32'h800; ex_pred_taken = 1'b0; ex_valid = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_valid", res_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_valid", res_valid, 1'b0);
        chk("async_rst_taken", res_taken, 1'b0);
        chk("async_rst_redirect", res_redirect_pc, 32'h0);
        check_stats();
        check_pred("async_rst_pred_14", 32'h14);
        check_pred("async_rst_pred_100", 32'h100);
        @(negedge clk);
        ex_valid = 1'b0;
        rst = 1'b0;

        // Statistics saturate at 2^CNT_W-1.
        for (int i = 0; i < 20; i++)
            do_branch(3'b000, 32'd0, 32'd0, 32'h200 + 32'(i * 4), 32'h900, 1'b0);
        chk("stat_br_sat", stat_branches, 4'hF);
        chk("stat_mis_sat", stat_mispredicts, 4'hF);
        chk("queue_empty", q_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_resolve_predict.md
Name: branch_resolve_predict

Overview:
Parametrised next-generation branch unit for the RV32IM core: resolves conditional branches in EX and trains a bimodal branch history table (BHT) of 2-bit saturating counters. Fetch reads the table to predict taken/not-taken. EX compares the resolved outcome against the prediction and produces a registered redirect/mispredict result one cycle later. Two saturating statistics counters support performance measurement.

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 64, number of 2-bit counters (power of two, >=2)
INIT_STATE, 2'b01, counter value after reset (weakly not-taken)
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
f_pc  input  XLEN  fetch PC for prediction lookup
f_pred_taken  output  1  combinational: selected counter[1]
ex_valid  input  1  EX holds a conditional branch this cycle
ex_stall  input  1  EX frozen; branch not accepted this cycle
ex_funct3  input  3  branch type (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu)
ex_a, ex_b  input  XLEN  rs1/rs2 operands
ex_pc  input  XLEN  branch PC
ex_target  input  XLEN  computed taken target
ex_pred_taken  input  1  prediction carried from fetch
res_valid  output  1  registered result valid
res_taken  output  1  resolved outcome
res_mispredict  output  1  resolved != predicted
res_redirect_pc  output  XLEN  ex_target if taken else ex_pc+4 (mod 2^XLEN)
res_illegal  output  1  funct3 was 010 or 011
stat_branches  output  CNT_W  accepted legal branches, saturating
stat_mispredicts  output  CNT_W  mispredictions, saturating

Behaviour:
- Clock clk; reset rst is asynchronous and active-high.
- Reset: all counters = INIT_STATE; res_valid, res_taken, res_mispredict, res_illegal = 0; res_redirect_pc = 0; stats = 0. Reset asserted mid-operation discards any in-flight result immediately.
- Index: idx = pc[log2(BHT_ENTRIES)+1:2], same mapping for fetch and EX.
- Accept = ex_valid & ~ex_stall. On an accept edge, res_* capture the outcome, giving 1-cycle latency. res_valid is 1 for exactly the cycle after each accept and 0 otherwise. res_* other than res_valid hold their last value when not accepting.
- Compare: signed for 100/101, unsigned for 110/111, equality for 000/001, all at full XLEN width.
- Illegal funct3 (010, 011): res_taken=0, res_mispredict=ex_pred_taken, res_illegal=1. No BHT update and no stat increment.
- Legal accept: counter[idx] moves +1 if taken, -1 if not, saturating at 00 and 11. stat_branches +1, and stat_mispredicts +1 if mispredicted. Both hold at all-ones.
- Same-cycle fetch read and EX write to one index: f_pred_taken returns the pre-update value; there is no bypass.
- Write and read in different cycles: a fetch in the cycle after the update sees the new value.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Decomposition:
- Shared package: branch funct3 constants (shared with the decoder and ALU control), counter encodings, and the INIT_STATE default.
- Sub-module bht_counter_array holds the BHT_ENTRIES x 2-bit storage, with one combinational read port, one write port, reset init and saturating update.
- Compare logic stays inline in the top module.

Test Plan:
- After reset, f_pc=0x100 -> f_pred_taken=0. Accept beq at pc 0x100, a=b=5, pred=0 -> next cycle res_taken=1, res_mispredict=1, redirect=ex_target. f_pred_taken(0x100)=1 afterwards.
- blt a=0xFFFFFFFF, b=1 -> taken. bltu with the same operands -> not taken, redirect=pc+4. For pc=0xFFFFFFFC, redirect=0x00000000.
- Four taken branches at the same PC -> counter saturates at 11. Then one not-taken -> 10, and prediction stays taken.
- ex_valid=1 with ex_stall=1 for 3 cycles -> res_valid stays 0, and the table and stats are unchanged. Releasing the stall gives a single res_valid pulse.
- funct3=010 accepted -> res_illegal=1, with table and stats unchanged.
- Same-cycle fetch and EX at index 5 -> old prediction returned. rst pulsed between edges -> outputs clear asynchronously and the table returns to 01.
- With CNT_W=4, 20 mispredicting branches -> both stats saturate at 15.
